// File: rtl/arrow_track_sequencer.sv
// Per-player scrolling arrow engine: steps the chart ROM into a 26-slot array,
// judges button presses at the target zone and keeps the hit indicator and score.
module arrow_track_sequencer #(
    parameter int          NUM_SLOTS   = 26,
    parameter logic [24:0] STEP_TICKS  = 25'd833333,
    parameter int          TARGET_SLOT = 23,
    parameter int          HOLD_STEPS  = 8,
    parameter int          CHART_AW    = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   press_valid,
    input  logic [2:0]             press_code,
    output logic [CHART_AW-1:0]    chart_addr,
    input  logic [2:0]             chart_data,
    output logic [3*NUM_SLOTS-1:0] arrow_array,
    output logic [1:0]             indicator,
    output logic [15:0]            score,
    output logic                   playing,
    output logic                   done
);

    // state | meaning
    // IDLE  | after reset, waiting for start
    // PLAY  | stepping chart entries into slot 0
    // DRAIN | end of chart seen, shifting zeros in until the array is empty
    // DONE  | chart finished, array empty, score frozen until start
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int                HOLD_W      = $clog2(HOLD_STEPS + 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_STEPS);

    logic [1:0]             state;
    logic [24:0]            tick;
    logic [HOLD_W-1:0]      hold;

    logic                   active;
    logic                   step;
    logic                   judge;
    logic                   code_ok;
    logic [2:0]             code_t;
    logic [2:0]             code_m;
    logic [2:0]             code_p;
    logic                   hit_t;
    logic                   hit_m;
    logic                   hit_p;
    logic [1:0]             judge_ind;
    logic [2:0]             slot0_in;
    logic [3*NUM_SLOTS-1:0] cleared;
    logic [3*NUM_SLOTS-1:0] shifted;
    logic                   miss;
    logic [16:0]            score_sum;
    logic [15:0]            score_next;

    assign active  = (state == S_PLAY) || (state == S_DRAIN);
    assign step    = active && (tick == STEP_TICKS - 25'd1);
    assign judge   = active && press_valid;
    assign playing = active;

    assign code_t  = arrow_array[3*TARGET_SLOT +: 3];
    assign code_m  = arrow_array[3*(TARGET_SLOT-1) +: 3];
    assign code_p  = arrow_array[3*(TARGET_SLOT+1) +: 3];
    assign code_ok = (press_code != 3'b000) && (press_code != 3'b111);

    // Priority: target slot, then the one above, then the one below.
    assign hit_t = judge && code_ok && (code_t == press_code);
    assign hit_m = judge && code_ok && !hit_t && (code_m == press_code);
    assign hit_p = judge && code_ok && !hit_t && !hit_m && (code_p == press_code);

    assign judge_ind = hit_t ? 2'b11 : ((hit_m || hit_p) ? 2'b10 : 2'b01);

    always_comb begin
        cleared = arrow_array;
        if (hit_t) cleared[3*TARGET_SLOT +: 3] = 3'b000;
        if (hit_m) cleared[3*(TARGET_SLOT-1) +: 3] = 3'b000;
        if (hit_p) cleared[3*(TARGET_SLOT+1) +: 3] = 3'b000;
    end

    // The end-of-chart code never enters the array; DRAIN feeds empties.
    assign slot0_in = ((state == S_PLAY) && (chart_data != 3'b111)) ? chart_data : 3'b000;
    assign shifted  = {cleared[3*NUM_SLOTS-4:0], slot0_in};
    assign miss     = step && (cleared[3*NUM_SLOTS-1 -: 3] != 3'b000);

    assign score_sum  = {1'b0, score} + (hit_t ? 17'd2 : ((hit_m || hit_p) ? 17'd1 : 17'd0));
    assign score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            tick        <= '0;
            hold        <= '0;
            arrow_array <= '0;
            indicator   <= 2'b00;
            score       <= '0;
            chart_addr  <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                state       <= S_PLAY;
                tick        <= '0;
                hold        <= '0;
                arrow_array <= '0;
                indicator   <= 2'b00;
                score       <= '0;
                chart_addr  <= '0;
            end else if (active) begin
                tick        <= step ? 25'd0 : tick + 25'd1;
                score       <= score_next;
                arrow_array <= step ? shifted : cleared;

                if (judge) begin
                    indicator <= judge_ind;
                    hold      <= HOLD_RELOAD;
                end else if (miss) begin
                    indicator <= 2'b01;
                    hold      <= HOLD_RELOAD;
                end else if (step && (hold != '0)) begin
                    hold <= hold - HOLD_W'(1);
                    if (hold == HOLD_W'(1)) indicator <= 2'b00;
                end

                if (step && (state == S_PLAY)) begin
                    chart_addr <= chart_addr + CHART_AW'(1);
                    if (chart_data == 3'b111) state <= S_DRAIN;
                end

                if (step && (state == S_DRAIN) && (shifted == '0)) begin
                    done  <= 1'b1;
                    state <= S_DONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_arrow_track_sequencer.sv
// Bench for arrow_track_sequencer: directed scenarios plus random play against a
// slot-array reference model, and a second instance driven to score saturation.
module tb_arrow_track_sequencer;

    localparam int NS    = 26;
    localparam int ST    = 4;
    localparam int TGT   = 23;
    localparam int HOLD  = 8;
    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    logic          clk;
    logic          reset;
    logic          start;
    logic          press_valid;
    logic [2:0]    press_code;
    logic [9:0]    chart_addr;
    logic [2:0]    chart_data;
    logic [77:0]   arrow_array;
    logic [1:0]    indicator;
    logic [15:0]   score;
    logic          playing;
    logic          done;

    logic          s_reset;
    logic          s_start;
    logic          s_press_valid;
    logic [2:0]    s_press_code;
    logic [9:0]    s_chart_addr;
    logic [2:0]    s_chart_data;
    logic [77:0]   s_arrow;
    logic [1:0]    s_ind;
    logic [15:0]   s_score;
    logic          s_playing;
    logic          s_done;

    logic [2:0]    rom [0:1023];

    int n_cmp = 0;
    int n_err = 0;

    int m_slot [NS];
    int m_score, m_ind, m_hold, m_mode, m_tick, m_addr;
    bit m_done, m_step;

    arrow_track_sequencer #(
        .NUM_SLOTS(NS), .STEP_TICKS(25'd4), .TARGET_SLOT(TGT), .HOLD_STEPS(HOLD), .CHART_AW(10)
    ) dut (
        .clock(clk), .reset(reset), .start(start), .press_valid(press_valid),
        .press_code(press_code), .chart_addr(chart_addr), .chart_data(chart_data),
        .arrow_array(arrow_array), .indicator(indicator), .score(score),
        .playing(playing), .done(done)
    );

    arrow_track_sequencer #(
        .NUM_SLOTS(NS), .STEP_TICKS(25'd2), .TARGET_SLOT(TGT), .HOLD_STEPS(HOLD), .CHART_AW(10)
    ) dut_sat (
        .clock(clk), .reset(s_reset), .start(s_start), .press_valid(s_press_valid),
        .press_code(s_press_code), .chart_addr(s_chart_addr), .chart_data(s_chart_data),
        .arrow_array(s_arrow), .indicator(s_ind), .score(s_score),
        .playing(s_playing), .done(s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous chart ROM: data follows the address by one cycle.
    always @(posedge clk) chart_data <= rom[chart_addr];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NS; k++) m_slot[k] = 0;
        m_score = 0; m_ind = 0; m_hold = 0; m_mode = M_IDLE;
        m_tick = 0; m_addr = 0; m_done = 0; m_step = 0;
    endtask

    function automatic logic [77:0] model_arrow();
        logic [77:0] v;
        for (int k = 0; k < NS; k++) v[3*k +: 3] = m_slot[k][2:0];
        return v;
    endfunction

    // One clock of the game rules: clear-by-press, then scroll, then indicator upkeep.
    task automatic model_clock(input logic st, input logic pv, input logic [2:0] pc);
        int cand [3];
        bit judged, found, missed, empty;
        int d;
        cand = '{TGT, TGT - 1, TGT + 1};
        m_done = 0;
        m_step = 0;
        if (st) begin
            for (int k = 0; k < NS; k++) m_slot[k] = 0;
            m_score = 0; m_ind = 0; m_hold = 0; m_addr = 0; m_tick = 0;
            m_mode = M_PLAY;
        end else if (m_mode == M_PLAY || m_mode == M_DRAIN) begin
            judged = 0;
            if (m_tick == ST - 1) begin m_step = 1; m_tick = 0; end
            else m_tick++;
            if (pv) begin
                judged = 1;
                m_ind  = 1;
                m_hold = HOLD;
                found  = 0;
                if (pc != 3'd0 && pc != 3'd7) begin
                    for (int i = 0; i < 3; i++) begin
                        if (!found && m_slot[cand[i]] == int'(pc)) begin
                            found = 1;
                            m_slot[cand[i]] = 0;
                            m_ind   = (i == 0) ? 3 : 2;
                            m_score = m_score + ((i == 0) ? 2 : 1);
                            if (m_score > 65535) m_score = 65535;
                        end
                    end
                end
            end
            if (m_step) begin
                missed = (m_slot[NS-1] != 0);
                d = int'(rom[m_addr]);
                for (int k = NS - 1; k > 0; k--) m_slot[k] = m_slot[k-1];
                m_slot[0] = (m_mode == M_PLAY && d != 7) ? d : 0;
                if (!judged) begin
                    if (missed) begin m_ind = 1; m_hold = HOLD; end
                    else if (m_hold > 0) begin
                        m_hold--;
                        if (m_hold == 0) m_ind = 0;
                    end
                end
                if (m_mode == M_PLAY) begin
                    m_addr = (m_addr + 1) % 1024;
                    if (d == 7) m_mode = M_DRAIN;
                end else begin
                    empty = 1;
                    for (int k = 0; k < NS; k++) if (m_slot[k] != 0) empty = 0;
                    if (empty) begin m_done = 1; m_mode = M_DONE; end
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("arrow", arrow_array, model_arrow());
        chk("indicator", indicator, m_ind);
        chk("score", score, m_score);
        chk("chart_addr", chart_addr, m_addr);
        chk("playing", playing, (m_mode == M_PLAY || m_mode == M_DRAIN));
        chk("done", done, m_done);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic cycle(input logic st, input logic pv, input logic [2:0] pc);
        start = st; press_valid = pv; press_code = pc;
        @(posedge clk);
        model_clock(st, pv, pc);
        @(negedge clk);
        start = 1'b0; press_valid = 1'b0; press_code = 3'd0;
        compare_all();
    endtask

    task automatic run_steps(input int n);
        int seen = 0;
        int budget = n * ST + 8;
        while (seen < n && budget > 0) begin
            cycle(1'b0, 1'b0, 3'd0);
            if (m_step) seen++;
            budget--;
        end
        chk("step_budget", seen, n);
    endtask

    task automatic load_rom(input logic [2:0] a0);
        for (int a = 0; a < 1024; a++) rom[a] = 3'd0;
        rom[0] = a0;
    endtask

    task automatic rand_phase(input int ncyc);
        logic st, pv;
        logic [2:0] pc;
        int r;
        for (int a = 0; a < 1024; a++) begin
            r = $urandom_range(0, 9);
            rom[a] = (r < 6) ? 3'd0 : ((r == 6) ? 3'd1 : ((r == 7) ? 3'd2 : ((r == 8) ? 3'd3 : 3'd4)));
            if ($urandom_range(0, 7) == 0) rom[a] = 3'd6;
        end
        rom[150] = 3'd7;
        rom[700] = 3'd7;
        for (int i = 0; i < ncyc; i++) begin
            st = (m_mode == M_IDLE) || ($urandom_range(0, 499) == 0) ||
                 (m_mode == M_DONE && $urandom_range(0, 9) == 0);
            pv = ($urandom_range(0, 2) == 0);
            r  = $urandom_range(0, 3);
            pc = (r == 0) ? 3'($urandom_range(0, 7)) :
                 (r == 1) ? m_slot[TGT][2:0] :
                 (r == 2) ? m_slot[TGT-1][2:0] : m_slot[TGT+1][2:0];
            cycle(st, pv, pc);
        end
    endtask

    task automatic main_seq();
        int done_cnt;
        int budget;
        reset = 1'b1; start = 1'b0; press_valid = 1'b0; press_code = 3'd0;
        load_rom(3'd0);
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        reset = 1'b0;
        @(negedge clk);
        compare_all();

        // Short chart, then drain to completion.
        load_rom(3'd1);
        rom[1] = 3'd0; rom[2] = 3'd2; rom[3] = 3'd7;
        cycle(1'b1, 1'b0, 3'd0);
        run_steps(4);
        chk("t2_slot0", arrow_array[0 +: 3], 3'b000);
        chk("t2_slot1", arrow_array[3 +: 3], 3'b010);
        chk("t2_slot2", arrow_array[6 +: 3], 3'b000);
        chk("t2_slot3", arrow_array[9 +: 3], 3'b001);
        chk("t2_addr", chart_addr, 10'd4);
        chk("t2_playing_drain", playing, 1'b1);
        done_cnt = 0;
        budget = 200;
        while (m_mode != M_DONE && budget > 0) begin
            cycle(1'b0, 1'b0, 3'd0);
            if (done) done_cnt++;
            budget--;
        end
        repeat (6) begin
            cycle(1'b0, 1'b0, 3'd0);
            if (done) done_cnt++;
        end
        chk("t2_done_pulses", done_cnt, 1);
        chk("t2_done_array", arrow_array, 78'd0);
        chk("t2_done_playing", playing, 1'b0);

        // Hit on the target slot, then on the slot above it.
        load_rom(3'd3);
        cycle(1'b1, 1'b0, 3'd0);
        run_steps(24);
        chk("t3_pre23", arrow_array[3*TGT +: 3], 3'b011);
        cycle(1'b0, 1'b1, 3'b011);
        chk("t3_slot23", arrow_array[3*TGT +: 3], 3'b000);
        chk("t3_ind", indicator, 2'b11);
        chk("t3_score", score, 16'd2);
        cycle(1'b1, 1'b0, 3'd0);
        run_steps(23);
        chk("t3b_pre22", arrow_array[3*(TGT-1) +: 3], 3'b011);
        cycle(1'b0, 1'b1, 3'b011);
        chk("t3b_slot22", arrow_array[3*(TGT-1) +: 3], 3'b000);
        chk("t3b_ind", indicator, 2'b10);
        chk("t3b_score", score, 16'd1);

        // Bad press, then the indicator decays after the hold period.
        cycle(1'b0, 1'b1, 3'b100);
        chk("t4_ind", indicator, 2'b01);
        chk("t4_score", score, 16'd1);
        run_steps(HOLD - 1);
        chk("t4_hold", indicator, 2'b01);
        run_steps(1);
        chk("t4_expire", indicator, 2'b00);

        // Unpressed arrow leaves the bottom as a miss.
        load_rom(3'd6);
        cycle(1'b1, 1'b0, 3'd0);
        run_steps(26);
        chk("t5_slot25", arrow_array[75 +: 3], 3'b110);
        chk("t5_ind_pre", indicator, 2'b00);
        run_steps(1);
        chk("t5_ind", indicator, 2'b01);
        chk("t5_gone", arrow_array, 78'd0);

        // Hit landing on the same cycle as a step.
        load_rom(3'd1);
        cycle(1'b1, 1'b0, 3'd0);
        run_steps(24);
        repeat (ST - 1) cycle(1'b0, 1'b0, 3'd0);
        cycle(1'b0, 1'b1, 3'b001);
        chk("t6_slot24", arrow_array[3*(TGT+1) +: 3], 3'b000);
        chk("t6_array", arrow_array, 78'd0);
        chk("t6_ind", indicator, 2'b11);
        chk("t6_score", score, 16'd2);

        rand_phase(3000);

        // Asynchronous reset in the middle of play.
        load_rom(3'd2);
        rom[1] = 3'd4; rom[2] = 3'd1;
        cycle(1'b1, 1'b0, 3'd0);
        run_steps(10);
        chk("t1_pre_nonempty", (arrow_array != 78'd0), 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("t1_arrow", arrow_array, 78'd0);
        chk("t1_ind", indicator, 2'b00);
        chk("t1_score", score, 16'd0);
        chk("t1_addr", chart_addr, 10'd0);
        chk("t1_playing", playing, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b0, 1'b1, 3'b010);
        chk("t1_idle_press", indicator, 2'b00);
    endtask

    // Second instance: one target-slot hit per step until the score pins at FFFF.
    task automatic sat_seq();
        int hits;
        int exp_score;
        s_reset = 1'b1; s_start = 1'b0; s_press_valid = 1'b0; s_press_code = 3'd0;
        s_chart_data = 3'b001;
        repeat (2) @(negedge clk);
        s_reset = 1'b0;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 24 + 32769; k++) begin
            if (k >= 25) begin
                s_press_valid = 1'b1;
                s_press_code  = 3'b001;
            end
            @(negedge clk);
            s_press_valid = 1'b0;
            hits = k - 24;
            if (hits == 1 || hits == 2 || hits == 1000 || hits >= 32767) begin
                exp_score = (2 * hits > 65535) ? 65535 : 2 * hits;
                chk("sat_score", s_score, exp_score);
                chk("sat_ind", s_ind, 2'b11);
                chk("sat_slot24", s_arrow[3*(TGT+1) +: 3], 3'b000);
                chk("sat_slot23", s_arrow[3*TGT +: 3], 3'b001);
                chk("sat_addr", s_chart_addr, k % 1024);
                chk("sat_done", s_done, 1'b0);
                chk("sat_playing", s_playing, 1'b1);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        fork
            main_seq();
            sat_seq();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arrow_track_sequencer.md
Name: arrow_track_sequencer

Overview:
- Per-player sequential engine that generates the scrolling arrow state consumed by the screen index/pixel renderer.
- Each step it reads the next chart entry from a synchronous chart ROM and shifts the 26-slot arrow array down one slot.
- It judges player button presses against the target zone and produces the 2-bit hit indicator and a score.
- Two instances are used, one for p1 and one for p2; their outputs feed p1/p2_arrow_array and p1/p2_indicator.

Parameters:
- NUM_SLOTS, 26, number of 3-bit arrow slots; the array is 3*NUM_SLOTS bits.
- STEP_TICKS, 25'd833333, clock cycles per scroll step; must be at least 2.
- TARGET_SLOT, 23, slot aligned with the on-screen arrow block (16*23 = y 368).
- HOLD_STEPS, 8, number of steps an indicator stays visible before reverting to 00.
- CHART_AW, 10, chart ROM address width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins play from chart address 0.
- press_valid  in  1  single-cycle pulse when a button event occurs.
- press_code  in  3  button code: 001 up, 010 left, 011 down, 100 right, 110 shake.
- chart_addr  out  CHART_AW  address presented to the chart ROM.
- chart_data  in  3  arrow code from the ROM, valid 1 cycle after chart_addr. 000 means empty; 111 means end of chart.
- arrow_array  out  3*NUM_SLOTS  slot k occupies bits [3k+2:3k]; slot 0 is the top of the screen.
- indicator  out  2  11 excellent, 10 good, 01 bad, 00 none.
- score  out  16  accumulated score.
- playing  out  1  high while in the PLAY or DRAIN state.
- done  out  1  single-cycle pulse when the chart has completed.

Behaviour:
- Reset (async, active-high): state IDLE. arrow_array, indicator, score, chart_addr, tick counter and hold counter all 0. playing=0, done=0.
- The FSM has four states:
  - IDLE: when start is seen, clear arrow_array, score, indicator and chart_addr; go to PLAY.
  - PLAY: the tick counter counts 0..STEP_TICKS-1. The step event fires on the cycle where the count equals STEP_TICKS-1; the counter then wraps to 0.
  - DRAIN: entered from PLAY when a step reads chart_data=111. Steps continue and slot 0 is loaded with 000. When every slot is 000 after a step, pulse done for 1 cycle and go to DONE.
  - DONE: holds arrow_array at all zeros and score frozen; start returns to PLAY after clearing, as in IDLE.
- start asserted in PLAY or DRAIN restarts the chart: clear everything and remain in or return to PLAY.
- Step event in PLAY:
  - slot[k] <= slot[k-1] for k=1..NUM_SLOTS-1.
  - slot[0] <= chart_data, or 000 if chart_data=111; 111 is never written into the array.
  - chart_addr increments, wrapping at 2^CHART_AW. Because chart_addr changes at a step and the next step is at least 2 cycles later, chart_data is always stable when sampled.
- Miss: if the slot being shifted out (slot NUM_SLOTS-1) is non-zero, that is a miss. Indicator <= 01, hold counter reloaded.
- Press judgement on press_valid in PLAY or DRAIN, using the array value before any same-cycle shift:
  - Candidate slots are TARGET_SLOT, TARGET_SLOT-1 and TARGET_SLOT+1, checked in that priority order.
  - The first slot whose code equals press_code is cleared to 000.
  - A match at TARGET_SLOT gives indicator 11 and score+2. A match at TARGET_SLOT±1 gives indicator 10 and score+1.
  - No match gives indicator 01, with score unchanged.
  - The hold counter is reloaded to HOLD_STEPS on every judgement.
  - press_code 000 or 111 always judges as bad.
- Simultaneous press and step:
  - The clear is applied first, then the shift, so a hit arrow never reappears one slot lower.
  - If a miss and a press judgement coincide, the press result drives indicator.
- Indicator hold: each step decrements the hold counter if it is non-zero. When it reaches 0, indicator <= 00.
- Score saturates at 16'hFFFF.
- Presses in IDLE or DONE are ignored.
- All outputs are registered; latency from press_valid to the indicator/score update is 1 cycle.

Test Plan:
1. Reset mid-PLAY with a non-empty array -> arrow_array=0, indicator=00, score=0, state IDLE immediately (asynchronous, no clock edge needed).
2. STEP_TICKS=4, chart {001,000,010,111}, start -> after 4 steps slot0..slot2 = 000,010,000 with slot3=001. chart_addr=4. DRAIN is entered and done pulses once when the last arrow exits slot 25.
3. Place 011 at slot 23, press_valid with code 011 -> slot 23 becomes 000 next cycle, indicator=11, score=2. The same press against slot 22 -> indicator=10, score=1.
4. Press 100 with no 100 in slots 22-24 -> indicator=01, score unchanged. After HOLD_STEPS=8 steps with no events, indicator=00.
5. Arrow 110 reaches slot 25 with no press, then a step -> indicator=01 and the arrow is gone from the array.
6. Press matching slot 23 on the exact step cycle -> slot 24 is 000 after the cycle, indicator=11. With score preloaded to FFFE, the hit saturates score to FFFF.
